seq_div_hs: RTL and testbench

Parametrised sequential radix-2 divider with valid/ready handshakes on both sides, a per-operation signed/unsigned mode, a pass-through tag, and explicit divide-by-zero and overflow handling. Successor to the fixed-width signed sequential divider in the VO arithmetic datapath. Serves pose-solver normalisation where results may back-pressure and several requesters share one divider by tag.

---
 rtl/seq_div_pkg.sv | 17 +
 rtl/seq_div_step.sv | 22 ++
 rtl/seq_div_hs.sv | 181 ++++++++++++++++++
 tb/tb_seq_div_hs.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared state encoding and constants for the handshaked sequential divider.
package seq_div_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StCalc = 3'b010,
        StDone = 3'b100
    } state_e;

    localparam int unsigned MaxWidth = 64;

    // Divide-by-zero quotient: all ones, right-aligned to width bits (width <= MaxWidth).
    function automatic logic [MaxWidth-1:0] div0_quot(input int unsigned width);
        div0_quot = {MaxWidth{1'b1}} >> (MaxWidth - width);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module seq_div_step #(
    parameter int unsigned DSOR_WIDTH = 32
) (
    input  logic [DSOR_WIDTH:0] rem_in,
    input  logic                dend_bit,
    input  logic [DSOR_WIDTH:0] dsor_mag,
    output logic [DSOR_WIDTH:0] rem_out,
    output logic                quot_bit
);

    logic [DSOR_WIDTH+1:0] shifted;
    logic [DSOR_WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem_in, dend_bit};
        diff     = shifted - {1'b0, dsor_mag};
        quot_bit = ~diff[DSOR_WIDTH+1];
        rem_out  = quot_bit ? diff[DSOR_WIDTH:0] : shifted[DSOR_WIDTH:0];
    end

endmodule

// File: rtl/seq_div_hs.sv
// Radix-2 sequential divider with valid/ready on both sides, signed/unsigned mode and tag.
// Optional SEQ_DIV_HS_BYPASS_EN: finish in one cycle when |dividend| < |divisor|.
module seq_div_hs
    import seq_div_pkg::*;
#(
    parameter int unsigned DEND_WIDTH = 32,
    parameter int unsigned DSOR_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DEND_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_signed,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [DEND_WIDTH-1:0] i_Dend,
    input  logic [DSOR_WIDTH-1:0] i_Dsor,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEND_WIDTH-1:0] o_Quot,
    output logic [DSOR_WIDTH-1:0] o_Rder,
    output logic                  o_div0,
    output logic [TAG_WIDTH-1:0]  o_tag
);

    localparam int unsigned CmpW = DEND_WIDTH + 1;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DEND_WIDTH-1:0] dq_q, dq_d;       // dividend shifts out MSB, quotient shifts in LSB
    logic [DSOR_WIDTH:0]   rem_q, rem_d;
    logic [DSOR_WIDTH:0]   dsor_q, dsor_d;
    logic                  mode_q, mode_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DEND_WIDTH-1:0] quot_q, quot_d;
    logic [DSOR_WIDTH-1:0] rder_q, rder_d;
    logic                  div0_q, div0_d;
    logic [TAG_WIDTH-1:0]  otag_q, otag_d;

    logic                  dend_neg, dsor_neg, dsor_zero, bypass;
    logic [DEND_WIDTH-1:0] dend_mag;
    logic [DSOR_WIDTH:0]   dsor_mag;
    logic [DSOR_WIDTH:0]   step_rem;
    logic                  step_q;
    logic [DEND_WIDTH-1:0] q_final;
    logic [DSOR_WIDTH-1:0] r_final;

    always_comb begin
        dend_neg  = i_signed & i_Dend[DEND_WIDTH-1];
        dsor_neg  = i_signed & i_Dsor[DSOR_WIDTH-1];
        dend_mag  = dend_neg ? -i_Dend : i_Dend;
        dsor_mag  = {1'b0, (dsor_neg ? -i_Dsor : i_Dsor)};
        dsor_zero = (i_Dsor == '0);
`ifdef SEQ_DIV_HS_BYPASS_EN
        bypass    = !dsor_zero && (CmpW'(dend_mag) < CmpW'(dsor_mag));
`else
        bypass    = 1'b0;
`endif
    end

    seq_div_step #(
        .DSOR_WIDTH (DSOR_WIDTH)
    ) u_step (
        .rem_in   (rem_q),
        .dend_bit (dq_q[DEND_WIDTH-1]),
        .dsor_mag (dsor_q),
        .rem_out  (step_rem),
        .quot_bit (step_q)
    );

    assign q_final = {dq_q[DEND_WIDTH-2:0], step_q};
    assign r_final = step_rem[DSOR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dsor_d  = dsor_q;
        mode_d  = mode_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        tag_d   = tag_q;
        quot_d  = quot_q;
        rder_d  = rder_q;
        div0_d  = div0_q;
        otag_d  = otag_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    mode_d  = i_signed;
                    q_neg_d = dend_neg ^ dsor_neg;
                    r_neg_d = dend_neg;
                    tag_d   = i_tag;
                    dq_d    = dend_mag;
                    dsor_d  = dsor_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (dsor_zero) begin
                        state_d = StDone;
                        quot_d  = DEND_WIDTH'(div0_quot(DEND_WIDTH));
                        rder_d  = i_Dend[DSOR_WIDTH-1:0];
                        div0_d  = 1'b1;
                        otag_d  = i_tag;
                    end else if (bypass) begin
                        // |dividend| < |divisor| so the signed dividend fits the remainder
                        state_d = StDone;
                        quot_d  = '0;
                        rder_d  = i_Dend[DSOR_WIDTH-1:0];
                        div0_d  = 1'b0;
                        otag_d  = i_tag;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                dq_d  = q_final;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(DEND_WIDTH - 1)) begin
                    state_d = StDone;
                    // Wrapped negation makes most-negative / -1 come out as most-negative
                    quot_d  = (mode_q & q_neg_q) ? -q_final : q_final;
                    rder_d  = (mode_q & r_neg_q) ? -r_final : r_final;
                    div0_d  = 1'b0;
                    otag_d  = tag_q;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dsor_q  <= '0;
            mode_q  <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            tag_q   <= '0;
            quot_q  <= '0;
            rder_q  <= '0;
            div0_q  <= 1'b0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dsor_q  <= dsor_d;
            mode_q  <= mode_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            tag_q   <= tag_d;
            quot_q  <= quot_d;
            rder_q  <= rder_d;
            div0_q  <= div0_d;
            otag_q  <= otag_d;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_Quot  = quot_q;
    assign o_Rder  = rder_q;
    assign o_div0  = div0_q;
    assign o_tag   = otag_q;

endmodule

// File: tb/tb_seq_div_hs.sv
// Directed self-checking bench for seq_div_hs at 32/32/4 widths.
module tb_seq_div_hs;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_signed;
    logic [3:0]  i_tag;
    logic [31:0] i_Dend;
    logic [31:0] i_Dsor;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_Quot;
    logic [31:0] o_Rder;
    logic        o_div0;
    logic [3:0]  o_tag;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int seen;

    seq_div_hs #(
        .DEND_WIDTH (32),
        .DSOR_WIDTH (32),
        .TAG_WIDTH  (4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_signed (i_signed),
        .i_tag    (i_tag),
        .i_Dend   (i_Dend),
        .i_Dsor   (i_Dsor),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_Quot   (o_Quot),
        .o_Rder   (o_Rder),
        .o_div0   (o_div0),
        .o_tag    (o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called just after a negedge with o_ready high; returns cycles from accept to o_valid.
    task automatic issue(input logic sgn, input logic [3:0] tg, input logic [31:0] dend,
                         input logic [31:0] dsor, output int l);
        i_valid  = 1'b1;
        i_signed = sgn;
        i_tag    = tg;
        i_Dend   = dend;
        i_Dsor   = dsor;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        l = 1;
        while (!o_valid && l < 100) begin
            @(negedge clk);
            l = l + 1;
        end
    endtask

    task automatic retire();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_signed = 1'b0;
        i_tag    = '0;
        i_Dend   = '0;
        i_Dsor   = '0;
        i_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 72'(o_ready), 72'd1);
        check("rst_valid", 72'(o_valid), 72'd0);
        check("rst_quot",  72'(o_Quot),  72'd0);
        check("rst_rder",  72'(o_Rder),  72'd0);
        check("rst_div0",  72'(o_div0),  72'd0);
        check("rst_tag",   72'(o_tag),   72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // -7 / 2 signed -> -3 rem -1
        issue(1'b1, 4'd5, 32'hFFFF_FFF9, 32'd2, lat);
        check("s7_lat",  72'(lat),    72'd33);
        check("s7_quot", 72'(o_Quot), 72'hFFFF_FFFD);
        check("s7_rder", 72'(o_Rder), 72'hFFFF_FFFF);
        check("s7_tag",  72'(o_tag),  72'd5);
        check("s7_div0", 72'(o_div0), 72'd0);
        retire();
        check("s7_idle", 72'(o_ready), 72'd1);

        issue(1'b0, 4'd1, 32'hFFFF_FFFF, 32'h10, lat);
        check("u16_quot", 72'(o_Quot), 72'h0FFF_FFFF);
        check("u16_rder", 72'(o_Rder), 72'hF);
        retire();

        // -1 / 16 signed -> 0 rem -1
        issue(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h10, lat);
        check("s16_quot", 72'(o_Quot), 72'd0);
        check("s16_rder", 72'(o_Rder), 72'hFFFF_FFFF);
        retire();

        issue(1'b1, 4'd6, 32'd100, 32'd0, lat);
        check("d0_lat",  72'(lat),    72'd1);
        check("d0_div0", 72'(o_div0), 72'd1);
        check("d0_quot", 72'(o_Quot), 72'hFFFF_FFFF);
        check("d0_rder", 72'(o_Rder), 72'd100);
        check("d0_tag",  72'(o_tag),  72'd6);
        retire();

        issue(1'b1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_quot", 72'(o_Quot), 72'h8000_0000);
        check("ovf_rder", 72'(o_Rder), 72'd0);
        check("ovf_div0", 72'(o_div0), 72'd0);
        retire();

        // 100 / 7 unsigned -> 14 rem 2, then backpressure with a pending 50 / -3 signed
        issue(1'b0, 4'd3, 32'd100, 32'd7, lat);
        check("bp_lat", 72'(lat), 72'd33);
        i_valid  = 1'b1;
        i_signed = 1'b1;
        i_tag    = 4'd9;
        i_Dend   = 32'd50;
        i_Dsor   = 32'hFFFF_FFFD;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {o_valid, o_ready, o_div0, o_tag, o_Rder, o_Quot},
                  {1'b1, 1'b0, 1'b0, 4'd3, 32'd2, 32'd14});
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("bp_ready_after_hs", 72'(o_ready), 72'd1);
        check("bp_valid_after_hs", 72'(o_valid), 72'd0);
        @(negedge clk);
        i_valid = 1'b0;
        check("bp_accepted", 72'(o_ready), 72'd0);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat = lat + 1;
        end
        check("bp2_lat",  72'(lat),    72'd33);
        check("bp2_quot", 72'(o_Quot), 72'hFFFF_FFF0);
        check("bp2_rder", 72'(o_Rder), 72'd2);
        check("bp2_tag",  72'(o_tag),  72'd9);
        retire();

        // Abort 1000 / 3 at CALC cycle 10
        i_valid  = 1'b1;
        i_signed = 1'b0;
        i_tag    = 4'd7;
        i_Dend   = 32'd1000;
        i_Dsor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 72'(o_valid), 72'd0);
        check("mid_rst_quot",  72'(o_Quot),  72'd0);
        check("mid_rst_rder",  72'(o_Rder),  72'd0);
        check("mid_rst_tag",   72'(o_tag),   72'd0);
        check("mid_rst_div0",  72'(o_div0),  72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 72'(o_ready), 72'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) seen = seen + 1;
        end
        check("lost_result", 72'(seen), 72'd0);

        issue(1'b0, 4'd2, 32'd12, 32'd5, lat);
        check("r12_lat",  72'(lat),    72'd33);
        check("r12_quot", 72'(o_Quot), 72'd2);
        check("r12_rder", 72'(o_Rder), 72'd2);
        check("r12_tag",  72'(o_tag),  72'd2);
        retire();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
